digit_entry_buffer: RTL and testbench

DIGIT_ENTRY_BUFFER -- requirements
Module: digit_entry_buffer

---
 rtl/digit_entry_buffer.sv | 143 ++++++++++++++
 tb/tb_digit_entry_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer
//   Collects NUM_DIGITS digits, one per rising edge of 'enter', into a
//   partial entry. The final enter edge commits the completed entry to
//   'code' and pulses 'code_valid' for one cycle. 'clear' aborts the
//   current entry. Rising-edge backspace removes the last digit.
//
//   Build option: define DIGIT_ENTRY_BACKSPACE_EN to enable backspace.
//   When it is undefined, the backspace port is present but ignored, and
//   no backspace edge register is built.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   digit_in    current switch value (DIGIT_W bits)
//   enter       debounced level; acts on its rising edge
//   backspace   level; acts on its rising edge
//   clear       single-cycle pulse; aborts the current entry
//   code        last committed code; first-entered digit in the MSBs
//   code_valid  one-cycle pulse when code is updated
//   entry       partial entry, laid out like code; unfilled slots are 0
//   digit_count number of digits held in entry
module digit_entry_buffer #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4,
  localparam int VW = DIGIT_W * NUM_DIGITS,
  localparam int CW = $clog2(NUM_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic          enter,
  input  logic          backspace,
  input  logic          clear,
  output logic [VW-1:0] code,
  output logic          code_valid,
  output logic [VW-1:0] entry,
  output logic [CW-1:0] digit_count
);

  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  typedef enum logic {COLLECT = 1'b0, COMMIT = 1'b1} state_t;

  state_t state_q, state_n;

  // Edge detection: the previous sample is registered, the current level
  // is the live input, so an input held high yields exactly one event.
  logic enter_q;
  logic enter_edge;
  logic bksp_edge;

  always_ff @(posedge clk) begin
    if (reset) enter_q <= 1'b0;
    else       enter_q <= enter;
  end

  assign enter_edge = enter & ~enter_q;

`ifdef DIGIT_ENTRY_BACKSPACE_EN
  logic bksp_q;

  always_ff @(posedge clk) begin
    if (reset) bksp_q <= 1'b0;
    else       bksp_q <= backspace;
  end

  assign bksp_edge = backspace & ~bksp_q;
`else
  logic unused_backspace;

  assign unused_backspace = backspace;
  assign bksp_edge        = 1'b0;
`endif

  // Datapath next-state. Priority: clear > backspace edge > enter edge.
  logic [VW-1:0] entry_n, code_n;
  logic [CW-1:0] count_n;
  logic          commit;
  int            off;

  always_comb begin
    entry_n = entry;
    code_n  = code;
    count_n = digit_count;
    commit  = 1'b0;
    off     = 0;
    if (clear) begin
      entry_n = '0;
      count_n = '0;
    end else if (bksp_edge) begin
      if (digit_count != '0) begin
        count_n = digit_count - 1'b1;
        // Vacated slot is the one just below the current count.
        off = (NUM_DIGITS - int'(digit_count)) * DIGIT_W;
        entry_n[off +: DIGIT_W] = '0;
      end
    end else if (enter_edge) begin
      if (digit_count == LAST) begin
        // Final slot is the LSB digit, always zero in entry here, so the
        // live digit is dropped straight into the committed code.
        code_n = entry;
        code_n[DIGIT_W-1:0] = digit_in;
        entry_n = '0;
        count_n = '0;
        commit  = 1'b1;
      end else begin
        off = (NUM_DIGITS - 1 - int'(digit_count)) * DIGIT_W;
        entry_n[off +: DIGIT_W] = digit_in;
        count_n = digit_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry       <= '0;
      code        <= '0;
      digit_count <= '0;
    end else begin
      entry       <= entry_n;
      code        <= code_n;
      digit_count <= count_n;
    end
  end

  // Commit FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      COLLECT: if (commit) state_n = COMMIT;
      COMMIT:  state_n = COLLECT;
      default: state_n = COLLECT;
    endcase
  end

  assign code_valid = (state_q == COMMIT);

endmodule

// File: tb/tb_digit_entry_buffer.sv
module tb_digit_entry_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, backspace, clear;
  logic [3:0]  digit_a;
  logic        enter_a;
  logic [15:0] code_a, entry_a;
  logic        valid_a;
  logic [2:0]  count_a;

  logic [2:0]  digit_b;
  logic        enter_b;
  logic [17:0] code_b, entry_b;
  logic        valid_b;
  logic [2:0]  count_b;

  digit_entry_buffer dut_a (
    .clk(clk), .reset(reset), .digit_in(digit_a), .enter(enter_a),
    .backspace(backspace), .clear(clear), .code(code_a),
    .code_valid(valid_a), .entry(entry_a), .digit_count(count_a)
  );

  digit_entry_buffer #(.DIGIT_W(3), .NUM_DIGITS(6)) dut_b (
    .clk(clk), .reset(reset), .digit_in(digit_b), .enter(enter_b),
    .backspace(backspace), .clear(clear), .code(code_b),
    .code_valid(valid_b), .entry(entry_b), .digit_count(count_b)
  );

  int tests = 0, fails = 0;
  int mon_tests = 0, mon_fails = 0;
  int vcnt_a = 0, vcnt_b = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  // Scoreboard: every code_valid pulse pops one expected code.
  always @(negedge clk) begin
    if (valid_a) begin
      vcnt_a++;
      mon_tests++;
      assert (qa.size() != 0) else begin
        mon_fails++;
        $error("FAIL sb_a_unexpected: got code 0x%0h, expected no code_valid", code_a);
      end
      if (qa.size() != 0) begin
        logic [31:0] e;
        e = qa.pop_front();
        mon_tests++;
        assert ({16'h0, code_a} === e) else begin
          mon_fails++;
          $error("FAIL sb_a_code: got 0x%0h, expected 0x%0h", code_a, e);
        end
      end
    end
    if (valid_b) begin
      vcnt_b++;
      mon_tests++;
      assert (qb.size() != 0) else begin
        mon_fails++;
        $error("FAIL sb_b_unexpected: got code 0%0o, expected no code_valid", code_b);
      end
      if (qb.size() != 0) begin
        logic [31:0] e;
        e = qb.pop_front();
        mon_tests++;
        assert ({14'h0, code_b} === e) else begin
          mon_fails++;
          $error("FAIL sb_b_code: got 0%0o, expected 0%0o", code_b, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press_a(input logic [3:0] d);
    @(negedge clk); digit_a = d; enter_a = 1'b1;
    @(negedge clk); enter_a = 1'b0;
  endtask

  task automatic press_b(input logic [2:0] d);
    @(negedge clk); digit_b = d; enter_b = 1'b1;
    @(negedge clk); enter_b = 1'b0;
  endtask

  task automatic bksp();
    @(negedge clk); backspace = 1'b1;
    @(negedge clk); backspace = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  int v0;
  logic [15:0] last_code;

  initial begin
    reset = 1'b1; backspace = 1'b0; clear = 1'b0;
    digit_a = '0; enter_a = 1'b0; digit_b = '0; enter_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_code", 32'(code_a), 32'h0);
    chk("rst_entry", 32'(entry_a), 32'h0);
    chk("rst_count", 32'(count_a), 32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);

    // Four digits commit to 0xABCD
    press_a(4'hA); press_a(4'hB); press_a(4'hC);
    chk("abc_count", 32'(count_a), 32'd3);
    chk("abc_entry", 32'(entry_a), 32'hABC0);
    qa.push_back(32'hABCD);
    press_a(4'hD);
    chk("abcd_valid", 32'(valid_a), 32'd1);
    chk("abcd_code", 32'(code_a), 32'hABCD);
    chk("abcd_count", 32'(count_a), 32'd0);
    chk("abcd_entry", 32'(entry_a), 32'h0);
    @(negedge clk);
    chk("abcd_valid_drop", 32'(valid_a), 32'd0);
    chk("abcd_code_hold", 32'(code_a), 32'hABCD);

    // Held enter counts once
    @(negedge clk); digit_a = 4'h3; enter_a = 1'b1;
    repeat (10) @(negedge clk);
    enter_a = 1'b0;
    chk("hold_count", 32'(count_a), 32'd1);
    chk("hold_entry", 32'(entry_a), 32'h3000);
    pulse_clear();
    chk("clr1_count", 32'(count_a), 32'd0);

    // Backspace sequence
    press_a(4'h1); press_a(4'h2);
    bksp();
`ifdef DIGIT_ENTRY_BACKSPACE_EN
    chk("bs_count", 32'(count_a), 32'd1);
    chk("bs_entry", 32'(entry_a), 32'h1000);
    press_a(4'h7); press_a(4'h8);
    qa.push_back(32'h1789);
    press_a(4'h9);
    chk("bs_code", 32'(code_a), 32'h1789);
    last_code = 16'h1789;
`else
    chk("bs_count", 32'(count_a), 32'd2);
    chk("bs_entry", 32'(entry_a), 32'h1200);
    press_a(4'h7);
    qa.push_back(32'h1278);
    press_a(4'h8);
    chk("bs_code", 32'(code_a), 32'h1278);
    press_a(4'h9);
    chk("bs_next_entry", 32'(entry_a), 32'h9000);
    pulse_clear();
    last_code = 16'h1278;
`endif

    // Clear together with an enter edge
    press_a(4'h5); press_a(4'h6);
    chk("pre_clr_count", 32'(count_a), 32'd2);
    #1 v0 = vcnt_a;
    @(negedge clk); clear = 1'b1; enter_a = 1'b1; digit_a = 4'h7;
    @(negedge clk); clear = 1'b0; enter_a = 1'b0;
    chk("clr_entry", 32'(entry_a), 32'h0);
    chk("clr_count", 32'(count_a), 32'd0);
    chk("clr_code", 32'(code_a), 32'(last_code));
    @(negedge clk);
    #1 chk("clr_no_valid", 32'(vcnt_a - v0), 32'd0);

    // Reset coincident with the final enter edge
    press_a(4'hF); press_a(4'hE); press_a(4'hD);
    #1 v0 = vcnt_a;
    @(negedge clk); reset = 1'b1; enter_a = 1'b1; digit_a = 4'hC;
    @(negedge clk); reset = 1'b0; enter_a = 1'b0;
    chk("rstmid_code", 32'(code_a), 32'h0);
    chk("rstmid_count", 32'(count_a), 32'd0);
    chk("rstmid_entry", 32'(entry_a), 32'h0);
    chk("rstmid_valid", 32'(valid_a), 32'd0);
    @(negedge clk);
    #1 chk("rstmid_no_valid", 32'(vcnt_a - v0), 32'd0);

    // Backspace outranks a simultaneous enter edge
    press_a(4'h1);
    @(negedge clk); backspace = 1'b1; enter_a = 1'b1; digit_a = 4'h2;
    @(negedge clk); backspace = 1'b0; enter_a = 1'b0;
`ifdef DIGIT_ENTRY_BACKSPACE_EN
    chk("prio_count", 32'(count_a), 32'd0);
    chk("prio_entry", 32'(entry_a), 32'h0);
`else
    chk("prio_count", 32'(count_a), 32'd2);
    chk("prio_entry", 32'(entry_a), 32'h1200);
`endif
    pulse_clear();

    // Wider configuration: 3-bit digits, 6 per code
    for (int i = 1; i <= 5; i++) press_b(3'(i));
    chk("b_entry5", 32'(entry_b), 32'o123450);
    chk("b_count5", 32'(count_b), 32'd5);
    qb.push_back(32'o123456);
    press_b(3'd6);
    chk("b_valid", 32'(valid_b), 32'd1);
    chk("b_code", 32'(code_b), 32'o123456);
    @(negedge clk);
    chk("b_valid_drop", 32'(valid_b), 32'd0);

    repeat (3) @(negedge clk);
    #1;
    chk("sb_a_drained", 32'(qa.size()), 32'd0);
    chk("sb_b_drained", 32'(qb.size()), 32'd0);
    chk("b_pulses", 32'(vcnt_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests + mon_tests, fails + mon_fails);
    $finish;
  end

endmodule
